pcp_vector_packer: RTL
======================

PCP_VECTOR_PACKER -- requirements
Module: pcp_vector_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 512, meaning AXI4-Stream tdata width in bits on both ports.
REQ-002 SHALL have parameter VEC_LEN, default 12, meaning number of (index, value) pairs per PCP vector.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_tdata, input, DATA_W; s_axis_tvalid, input, 1; s_axis_tlast, input, 1; s_axis_tready, output, 1; together these form the upstream AXI4-Stream slave.
REQ-006 SHALL have ports m_axis_tdata, output, DATA_W; m_axis_tvalid, output, 1; m_axis_tlast, output, 1; m_axis_tready, input, 1; together these form the downstream AXI4-Stream master.
REQ-007 SHALL have port vec_count, output, 16, number of vectors emitted.
REQ-008 SHALL have port err_count, output, 16, number of vectors dropped.
REQ-009 SHALL have port err_pulse, output, 1, one-cycle pulse when a vector is dropped.

Function
REQ-010 Input framing SHALL be pairs of beats: an index beat (index = tdata[7:0]) followed by a value beat (value = tdata[7:0]); a vector is VEC_LEN pairs, with tlast only on the value beat of the final pair.
REQ-011 The FSM SHALL have states IDX, VAL, DRAIN and FLUSH; the reset state is IDX.
REQ-012 A transfer SHALL occur only on a cycle with tvalid and tready both high; nothing else advances state.
REQ-013 s_axis_tready SHALL be 1 in IDX, VAL and FLUSH, and 0 in DRAIN.
REQ-014 In IDX, an accepted beat SHALL latch its index and move to VAL.
REQ-015 In VAL, an accepted beat SHALL write its value into buffer[index], set valid bit [index], increment pair_cnt, and return to IDX.
REQ-016 In VAL, after the pair with pair_cnt reaching VEC_LEN and tlast=1, the FSM SHALL go to DRAIN.
REQ-017 An error SHALL occur on any of:
- index >= VEC_LEN;
- index whose valid bit is already set (duplicate);
- tlast on an index beat;
- tlast on a value beat before pair VEC_LEN;
- value beat of pair VEC_LEN with tlast=0.
REQ-018 On an error, the block SHALL pulse err_pulse, increment err_count, clear all valid bits and pair_cnt, and emit nothing for that vector.
REQ-019 After an error, if the offending beat carried tlast the FSM SHALL go to IDX; otherwise it SHALL go to FLUSH.
REQ-020 FLUSH SHALL discard beats until a beat with tlast is accepted, then go to IDX.
REQ-021 DRAIN SHALL emit VEC_LEN beats in ascending index order 0..VEC_LEN-1.
REQ-022 Each DRAIN beat SHALL carry tdata[7:0]=index and tdata[15:8]=value, with all other bits zero.
REQ-023 m_axis_tlast SHALL be 1 only on the beat for index VEC_LEN-1.
REQ-024 The first m_axis_tvalid SHALL assert in the cycle after the final value beat is accepted (latency 1).
REQ-025 Once m_axis_tvalid is asserted, m_axis_tvalid, tdata and tlast SHALL be held stable until m_axis_tready=1; the next beat follows with no bubble.
REQ-026 After the tlast beat is accepted, the block SHALL clear the valid bits, increment vec_count, and return to IDX in the next cycle.
REQ-027 vec_count and err_count SHALL wrap modulo 2^16.
REQ-028 err_pulse SHALL be asserted exactly one cycle per dropped vector, in the cycle after the offending beat.

Reset
REQ-029 While aresetn=0, the block SHALL force: state=IDX, pair_cnt=0, valid bits=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, vec_count=0, err_count=0, err_pulse=0.
REQ-030 Reset assertion mid-vector or mid-drain SHALL abandon that vector immediately, with no counter update.
REQ-031 s_axis_tready SHALL rise no earlier than the first aclk edge after aresetn deasserts.

Verification
REQ-032 Scenario: 12 pairs (index k, value 0x9E), k=0..11, tlast on the final beat, tready always 1 -> 12 output beats, each with tdata[15:0]=0x9E<<8|k, tlast on k=11, vec_count=1.
REQ-033 Scenario: the same pairs sent with indices in the order 11..0 -> output is still in index order 0..11.
REQ-034 Scenario: m_axis_tready oscillates 2 cycles low, 6 cycles high, over 3 back-to-back vectors -> outputs are stable while stalled, no loss or duplication, vec_count=3.
REQ-035 Scenario: tlast asserted on the value beat of pair 5 -> err_pulse once, err_count=1, no output; the following good vector is emitted correctly.
REQ-036 Scenario: index 0x0C in pair 3 -> error, FLUSH until tlast, then the next vector passes.
REQ-037 Scenario: aresetn pulsed low during DRAIN at beat 4 -> m_axis_tvalid=0 immediately, both counters=0, and the next vector is emitted in full.

Source files
------------

// File: rtl/pcp_vector_packer.sv
// pcp_vector_packer: gathers (index, value) pairs into one PCP vector and drains it in index order.
// A malformed vector is dropped whole and counted; the rest of its frame is flushed up to tlast.
module pcp_vector_packer #(
    parameter int DATA_W  = 512,
    parameter int VEC_LEN = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [15:0]       vec_count,
    output logic [15:0]       err_count,
    output logic              err_pulse
);
    localparam int IW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [7:0] VL8 = 8'(VEC_LEN);
    localparam logic [CW-1:0] LASTP = CW'(VEC_LEN - 1);
    localparam logic [IW-1:0] LASTI = IW'(VEC_LEN - 1);
    typedef enum logic [1:0] {IDX, VAL, DRAIN, FLUSH} state_t;
    state_t state;
    logic [IW-1:0] idx_r, drn, rd;
    logic [CW-1:0] pair_cnt;
    logic [2**IW-1:0] vld;
    logic [7:0] vbuf [2**IW];
    logic [7:0] sbyte, rd_val;
    logic [DATA_W-1:0] beat;
    logic s_fire, m_fire, final_pair, idx_bad, err;
    logic unused_hi;
    assign sbyte      = s_axis_tdata[7:0];
    assign unused_hi  = ^s_axis_tdata[DATA_W-1:8];
    assign s_fire     = s_axis_tvalid && s_axis_tready;
    assign m_fire     = m_axis_tvalid && m_axis_tready;
    assign final_pair = pair_cnt == LASTP;
    assign idx_bad    = (sbyte >= VL8) || vld[sbyte[IW-1:0]];
    assign err        = s_fire && (state == IDX ? (s_axis_tlast || idx_bad)
                                                : state == VAL && (s_axis_tlast != final_pair));
    // Beat 0 is loaded while the final value is still being written, so bypass it.
    assign rd     = state == DRAIN ? drn + 1'b1 : '0;
    assign rd_val = (state == VAL && idx_r == rd) ? sbyte : vbuf[rd];
    assign beat   = DATA_W'({rd_val, 8'(rd)});
    always_ff @(posedge aclk) begin
        if (state == VAL && s_fire && !err) vbuf[idx_r] <= sbyte;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDX;
            idx_r         <= '0;
            drn           <= '0;
            pair_cnt      <= '0;
            vld           <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            vec_count     <= '0;
            err_count     <= '0;
            err_pulse     <= 1'b0;
        end else begin
            err_pulse     <= err;
            s_axis_tready <= state != DRAIN;
            if (err) begin
                err_count <= err_count + 16'd1;
                vld       <= '0;
                pair_cnt  <= '0;
                state     <= s_axis_tlast ? IDX : FLUSH;
            end else begin
                case (state)
                    IDX: if (s_fire) begin
                        idx_r <= sbyte[IW-1:0];
                        state <= VAL;
                    end
                    VAL: if (s_fire) begin
                        vld[idx_r] <= 1'b1;
                        pair_cnt   <= pair_cnt + 1'b1;
                        state      <= final_pair ? DRAIN : IDX;
                        if (final_pair) begin
                            s_axis_tready <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= beat;
                            m_axis_tlast  <= rd == LASTI;
                            drn           <= '0;
                        end
                    end
                    DRAIN: if (m_fire) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            vld           <= '0;
                            pair_cnt      <= '0;
                            vec_count     <= vec_count + 16'd1;
                            s_axis_tready <= 1'b1;
                            state         <= IDX;
                        end else begin
                            drn          <= rd;
                            m_axis_tdata <= beat;
                            m_axis_tlast <= rd == LASTI;
                        end
                    end
                    FLUSH: if (s_fire && s_axis_tlast) state <= IDX;
                endcase
            end
        end
    end
endmodule
